// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and open-drain pin signals between a host controller and the PS/2 transmitter
interface ps2_host_tx_if;
  logic       i_tx_start;
  logic [7:0] i_tx_data;
  logic       i_ps2_clk_in;
  logic       i_ps2_dat_in;
  logic       o_ps2_clk_oe;
  logic       o_ps2_dat_oe;
  logic       o_tx_busy;
  logic       o_tx_done;
  logic       o_tx_error;
  modport slave (
    input  i_tx_start, i_tx_data, i_ps2_clk_in, i_ps2_dat_in,
    output o_ps2_clk_oe, o_ps2_dat_oe, o_tx_busy, o_tx_done, o_tx_error
  );
  modport master (
    output i_tx_start, i_tx_data, i_ps2_clk_in, i_ps2_dat_in,
    input  o_ps2_clk_oe, o_ps2_dat_oe, o_tx_busy, o_tx_done, o_tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter driving the shared open-drain pins through pull-low enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_CYCLES  = 8
) (
  input logic CLOCK_50,
  input logic rst,
  ps2_host_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, ERR} state_t;
  state_t      r_state, w_state_n;
  logic [1:0]  r_clk_s, r_dat_s;
  logic        r_clk_f, r_clk_q, r_dat_oe, w_dat_oe_n;
  logic [7:0]  r_fcnt;
  logic [19:0] r_timer, w_timer_n;
  logic [3:0]  r_bitcnt, w_bitcnt_n;
  logic [9:0]  r_shift, w_shift_n;
  logic        w_fall, w_timeout, w_done;
  assign w_fall    = r_clk_q & ~r_clk_f;
  assign w_timeout = r_timer == 20'(TIMEOUT_CYCLES - 1);
  assign w_done    = r_state == WAIT_IDLE && !w_timeout && r_clk_f && r_dat_s[1];
  assign bus.o_ps2_clk_oe = ~rst & (r_state == INHIBIT || r_state == RTS);
  assign bus.o_ps2_dat_oe = ~rst & r_dat_oe;
  assign bus.o_tx_busy    = ~rst & r_state != IDLE && r_state != ERR && !w_done;
  assign bus.o_tx_done    = ~rst & w_done;
  assign bus.o_tx_error   = ~rst & r_state == ERR;
  // Synchronize both pins and require a stable run before the filtered clock may change
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_clk_f <= 1'b1;
      r_clk_q <= 1'b1;
      r_fcnt  <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], bus.i_ps2_clk_in};
      r_dat_s <= {r_dat_s[0], bus.i_ps2_dat_in};
      r_clk_q <= r_clk_f;
      r_fcnt  <= (r_clk_s[1] == r_clk_f || r_fcnt == 8'(FILTER_CYCLES - 1)) ? '0 : r_fcnt + 8'd1;
      if (r_clk_s[1] != r_clk_f && r_fcnt == 8'(FILTER_CYCLES - 1)) r_clk_f <= r_clk_s[1];
    end
  end
  // Frame state and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_dat_oe <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_timer  <= w_timer_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_dat_oe <= w_dat_oe_n;
    end
  end
  // Next state: data line only moves on a filtered falling edge, the timeout beats a late ACK
  always_comb begin
    w_state_n  = r_state;
    w_timer_n  = r_timer;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_dat_oe_n = r_dat_oe;
    case (r_state)
      IDLE: if (bus.i_tx_start) begin
        w_shift_n = {1'b1, ~^bus.i_tx_data, bus.i_tx_data};
        w_timer_n = '0;
        w_state_n = INHIBIT;
      end
      INHIBIT: if (r_timer == 20'(INHIBIT_CYCLES - 1)) begin
        w_dat_oe_n = 1'b1;
        w_state_n  = RTS;
      end else w_timer_n = r_timer + 20'd1;
      RTS: begin
        w_timer_n  = '0;
        w_bitcnt_n = '0;
        w_state_n  = SEND;
      end
      SEND: begin
        w_timer_n = r_timer + 20'd1;
        if (w_timeout) begin
          w_dat_oe_n = 1'b0;
          w_state_n  = ERR;
        end else if (w_fall) begin
          w_dat_oe_n = ~r_shift[r_bitcnt];
          w_bitcnt_n = r_bitcnt + 4'd1;
          w_state_n  = r_bitcnt == 4'd9 ? ACK : SEND;
        end
      end
      ACK: begin
        w_timer_n = r_timer + 20'd1;
        w_state_n = w_timeout ? ERR : w_fall ? (r_dat_s[1] ? ERR : WAIT_IDLE) : ACK;
      end
      WAIT_IDLE: begin
        w_timer_n = r_timer + 20'd1;
        w_state_n = w_timeout ? ERR : w_done ? IDLE : WAIT_IDLE;
      end
      ERR: begin
        w_dat_oe_n = 1'b0;
        w_state_n  = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 host-transmit bench with a device model and a scoreboard monitor
module tb_ps2_host_tx;
  localparam int INH = 50, TO = 3000, FILT = 4, HALF = 40;
  logic clk = 1'b0, rst = 1'b1, dev_clk = 1'b1, dev_dat = 1'b1, clk_oe_q = 1'b0;
  logic [9:0] dev_frame = '0;
  int checks = 0, errors = 0, cyc_n = 0, t_rel = 0, t_err = 0;
  typedef struct {bit ok; logic [9:0] frame;} exp_t;
  exp_t exp_q[$];
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_CYCLES(FILT)) dut (
    .CLOCK_50(clk), .rst(rst), .bus(bus)
  );
  assign bus.i_ps2_clk_in = dev_clk & ~bus.o_ps2_clk_oe;
  assign bus.i_ps2_dat_in = dev_dat & ~bus.o_ps2_dat_oe;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference frame as the device sees it on its rising edges: data LSB first, odd parity, stop
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones = $countones(d);
    return {1'b1, 1'(ones % 2 == 0), d};
  endfunction

  // Monitor: every done/error pulse consumes one expected outcome
  always @(negedge clk) begin : mon
    exp_t e;
    cyc_n++;
    if (clk_oe_q && !bus.o_ps2_clk_oe) t_rel = cyc_n;
    clk_oe_q = bus.o_ps2_clk_oe;
    if (bus.o_tx_done || bus.o_tx_error) begin
      if (bus.o_tx_error) t_err = cyc_n;
      check("busy_at_pulse", 32'(bus.o_tx_busy), 32'(0));
      if (exp_q.size() == 0) check("unexpected_pulse", 32'({bus.o_tx_done, bus.o_tx_error}), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("outcome_done_err", 32'({bus.o_tx_done, bus.o_tx_error}), e.ok ? 32'(2) : 32'(1));
        if (e.ok) check("frame_bits", 32'(dev_frame), 32'(e.frame));
      end
    end
  end

  // Device: wait for request-to-send, then clock nclk bits; mode 0 ACK, 1 NACK, 2 silent
  task automatic device(input int mode, input int nclk, input bit inject);
    int w = 0;
    while (!(bus.o_ps2_clk_oe === 1'b0 && bus.o_ps2_dat_oe === 1'b1) && w < 1000) begin
      cyc(1);
      w++;
    end
    check("rts_seen", 32'(w < 1000), 32'(1));
    if (mode == 2 || w >= 1000) return;
    cyc(100);
    for (int k = 0; k < nclk; k++) begin
      if (k == 10) dev_dat = (mode == 1);
      dev_clk = 1'b0;
      if (inject && k == 5) begin
        bus.i_tx_data = 8'h55;
        bus.i_tx_start = 1'b1;
        cyc(1);
        bus.i_tx_start = 1'b0;
        cyc(HALF - 1);
      end else cyc(HALF);
      dev_clk = 1'b1;
      if (k < 10) dev_frame[k] = bus.i_ps2_dat_in;
      cyc(HALF);
    end
    dev_dat = 1'b1;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < TO + 2000) begin
      cyc(1);
      w++;
    end
    check("outcome_arrived", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    cyc(5);
  endtask

  task automatic send(input logic [7:0] d, input int mode, input bit inject);
    exp_q.push_back('{ok: mode == 0, frame: frame_of(d)});
    bus.i_tx_data = d;
    bus.i_tx_start = 1'b1;
    cyc(1);
    bus.i_tx_start = 1'b0;
    check("busy_after_start", 32'(bus.o_tx_busy), 32'(1));
    check("clk_oe_after_start", 32'(bus.o_ps2_clk_oe), 32'(1));
    device(mode, 11, inject);
    drain();
  endtask

  initial begin
    int d;
    bus.i_tx_start = 1'b0;
    bus.i_tx_data = 8'h00;
    cyc(3);
    @(negedge clk);
    check("rst_clk_oe", 32'(bus.o_ps2_clk_oe), 32'(0));
    check("rst_dat_oe", 32'(bus.o_ps2_dat_oe), 32'(0));
    check("rst_busy", 32'(bus.o_tx_busy), 32'(0));
    check("rst_done", 32'(bus.o_tx_done), 32'(0));
    check("rst_error", 32'(bus.o_tx_error), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(20);
    send(8'hED, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'h3C, 2, 1'b0);
    d = t_err - t_rel;
    check("timeout_cycles", 32'(d), (d >= TO - 1 && d <= TO + 1) ? 32'(d) : 32'(TO));
    check("timeout_clk_oe", 32'(bus.o_ps2_clk_oe), 32'(0));
    check("timeout_dat_oe", 32'(bus.o_ps2_dat_oe), 32'(0));
    send(8'hA7, 1, 1'b0);
    bus.i_tx_data = 8'hC3;
    bus.i_tx_start = 1'b1;
    cyc(1);
    bus.i_tx_start = 1'b0;
    device(0, 3, 1'b0);
    dev_clk = 1'b0;
    cyc(FILT + 10);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clk_oe", 32'(bus.o_ps2_clk_oe), 32'(0));
    check("midrst_busy", 32'(bus.o_tx_busy), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_clk_oe", 32'(bus.o_ps2_clk_oe), 32'(0));
    check("postrst_dat_oe", 32'(bus.o_ps2_dat_oe), 32'(0));
    check("postrst_busy", 32'(bus.o_tx_busy), 32'(0));
    dev_clk = 1'b1;
    cyc(30);
    send(8'hFF, 0, 1'b0);
    send(8'h96, 0, 1'b1);
    for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0) ? 1 : 0, 1'b0);
    cyc(20);
    check("final_idle_busy", 32'(bus.o_tx_busy), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
